// File: rtl/cv32e41s_bus_pkg.sv
// Shared types and helpers for the OBI round-robin arbiter slice.
package cv32e41s_bus_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;

    typedef struct packed {
        logic                  req;
        logic [OBI_ADDR_W-1:0] addr;
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  rvalid;
        logic [OBI_DATA_W-1:0] rdata;
        logic                  err;
    } obi_rsp_t;

    // LOCK_HELD: a request was offered but not granted; selection is frozen.
    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    function automatic int unsigned host_id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cv32e41s_obi_rr_arbiter_if.sv
// Host-side and target-side OBI signals of the arbiter, named from the arbiter's view.
// Handshake: a request transfers on a rising edge where req and gnt are both high;
// a response is a single-cycle rvalid pulse, returned in request order.
interface cv32e41s_obi_rr_arbiter_if
    import cv32e41s_bus_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32
);
    localparam int unsigned BeW  = DataWidth / 8;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [NrHosts-1:0]                   host_req_i;
    logic [NrHosts-1:0]                   host_gnt_o;
    logic [NrHosts-1:0][AddressWidth-1:0] host_addr_i;
    logic [NrHosts-1:0]                   host_we_i;
    logic [NrHosts-1:0][BeW-1:0]          host_be_i;
    logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i;
    logic [NrHosts-1:0]                   host_rvalid_o;
    logic [NrHosts-1:0][DataWidth-1:0]    host_rdata_o;
    logic [NrHosts-1:0]                   host_err_o;

    logic                    mem_req_o;
    logic [AddressWidth-1:0] mem_addr_o;
    logic                    mem_we_o;
    logic [BeW-1:0]          mem_be_o;
    logic [DataWidth-1:0]    mem_wdata_o;
    logic                    mem_gnt_i;
    logic                    mem_rvalid_i;
    logic [DataWidth-1:0]    mem_rdata_i;
    logic                    mem_err_i;

    logic [CntW-1:0] outstanding_o;
    logic            spurious_rvalid_o;
    lock_state_e     lock_dbg_o;

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output outstanding_o, spurious_rvalid_o, lock_dbg_o
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  outstanding_o, spurious_rvalid_o, lock_dbg_o
    );

endinterface

// File: rtl/cv32e41s_id_fifo.sv
// In-order FIFO of host IDs for accepted-but-unanswered transactions.
module cv32e41s_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [Width-1:0]             data_i,
    output logic [Width-1:0]             head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok, pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage needs no reset: occupancy alone says which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cv32e41s_obi_rr_arbiter.sv
// Round-robin OBI arbiter: N hosts share one target; a request that is offered but
// not granted stays locked to its host, and response routing follows an ID FIFO.
module cv32e41s_obi_rr_arbiter
    import cv32e41s_bus_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    cv32e41s_obi_rr_arbiter_if.slave    bus
);
    localparam int unsigned IdW  = host_id_width(NrHosts);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned BeW  = DataWidth / 8;
    localparam logic [IdW-1:0] LastId = IdW'(NrHosts - 1);

    lock_state_e       lock_q;
    logic [IdW-1:0]    locked_sel_q, rr_ptr_q;
    logic              spurious_q;
    logic [IdW-1:0]    arb_sel, sel, fifo_head;
    logic              mem_req, accept, pop, fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;

    logic [AddressWidth-1:0] sel_addr;
    logic                    sel_we;
    logic [BeW-1:0]          sel_be;
    logic [DataWidth-1:0]    sel_wdata;

    always_comb begin
        int unsigned idx;
        logic [IdW-1:0] cand;
        logic found;
        arb_sel = rr_ptr_q;
        found   = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            idx  = (int'(rr_ptr_q) + i) % NrHosts;
            cand = IdW'(idx);
            if (!found && bus.host_req_i[cand]) begin
                arb_sel = cand;
                found   = 1'b1;
            end
        end
    end

    assign sel = (lock_q == LOCK_HELD) ? locked_sel_q : arb_sel;
    // Gating with rst_i keeps the target port quiet while reset is asserted.
    assign mem_req = !rst_i && bus.host_req_i[sel] && !fifo_full;
    assign accept  = mem_req && bus.mem_gnt_i;
    assign pop     = bus.mem_rvalid_i && !fifo_empty;

    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_wdata = '0;
        if (mem_req) begin
            sel_addr  = bus.host_addr_i[sel];
            sel_we    = bus.host_we_i[sel];
            sel_be    = bus.host_be_i[sel];
            sel_wdata = bus.host_wdata_i[sel];
        end
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_addr_o  = sel_addr;
    assign bus.mem_we_o    = sel_we;
    assign bus.mem_be_o    = sel_be;
    assign bus.mem_wdata_o = sel_wdata;

    always_comb begin
        bus.host_gnt_o    = '0;
        bus.host_rvalid_o = '0;
        bus.host_rdata_o  = '0;
        bus.host_err_o    = '0;
        if (accept) bus.host_gnt_o[sel] = 1'b1;
        if (pop) begin
            bus.host_rvalid_o[fifo_head] = 1'b1;
            bus.host_rdata_o[fifo_head]  = bus.mem_rdata_i;
            bus.host_err_o[fifo_head]    = bus.mem_err_i;
        end
    end

    assign bus.outstanding_o     = fifo_count;
    assign bus.spurious_rvalid_o = spurious_q;
    assign bus.lock_dbg_o        = lock_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q       <= LOCK_IDLE;
            locked_sel_q <= '0;
            rr_ptr_q     <= '0;
            spurious_q   <= 1'b0;
        end else begin
            case (lock_q)
                LOCK_IDLE: if (mem_req && !bus.mem_gnt_i) begin
                    lock_q       <= LOCK_HELD;
                    locked_sel_q <= sel;
                end
                LOCK_HELD: if (accept) lock_q <= LOCK_IDLE;
                default:   lock_q <= LOCK_IDLE;
            endcase
            if (accept) rr_ptr_q <= (sel == LastId) ? '0 : sel + IdW'(1);
            if (bus.mem_rvalid_i && fifo_empty) spurious_q <= 1'b1;
        end
    end

    cv32e41s_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .pop_i   (pop),
        .data_i  (sel),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_cv32e41s_obi_rr_arbiter.sv
// Bench for the OBI round-robin arbiter: vector table plus reset/spurious sequences.
module tb_cv32e41s_obi_rr_arbiter;
    import cv32e41s_bus_pkg::*;

    localparam int unsigned NH = 2;
    localparam int unsigned MO = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cv32e41s_obi_rr_arbiter_if #(.NrHosts(NH), .MaxOutstanding(MO), .DataWidth(DW), .AddressWidth(AW)) bus ();

    cv32e41s_obi_rr_arbiter #(.NrHosts(NH), .MaxOutstanding(MO), .DataWidth(DW), .AddressWidth(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        exp_req;
        logic [1:0]  exp_gnt;
        logic        exp_sel;
        logic [1:0]  exp_cnt;
    } vec_t;

    vec_t        vecs[$];
    logic        id_q[$];
    logic [33:0] exp_q[$];   // {host id, err, rdata}

    int checks = 0;
    int errors = 0;

    logic [31:0] h_addr  [NH];
    logic        h_we    [NH];
    logic [3:0]  h_be    [NH];
    logic [31:0] h_wdata [NH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd,
                       input logic err, input logic er, input logic [1:0] eg, input logic es,
                       input logic [1:0] ec);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rd; v.err = err;
        v.exp_req = er; v.exp_gnt = eg; v.exp_sel = es; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    // driver
    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic [31:0] rd, input logic err);
        bus.host_req_i   = req;
        bus.mem_gnt_i    = gnt;
        bus.mem_rvalid_i = rv;
        bus.mem_rdata_i  = rd;
        bus.mem_err_i    = err;
        for (int h = 0; h < NH; h++) begin
            h_wdata[h] = $urandom_range(32'hFFFF_FFFF, 0);
            bus.host_wdata_i[h] = h_wdata[h];
        end
    endtask

    // scoreboard side: compare whatever the DUT returns this cycle
    task automatic check_rsp(input string tag);
        logic [33:0] e;
        logic        hid;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            hid = e[33];
            chk({tag, " rvalid"}, bus.host_rvalid_o, 2'b01 << hid);
            chk({tag, " rdata"},  bus.host_rdata_o[hid], e[31:0]);
            chk({tag, " err"},    bus.host_err_o[hid], e[32]);
            chk({tag, " other_rdata"}, bus.host_rdata_o[hid ^ 1'b1], 0);
        end else begin
            chk({tag, " no_rvalid"}, bus.host_rvalid_o, 0);
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string tag;
        tag = $sformatf("v%0d", n);
        drive(v.req, v.gnt, v.rv, v.rdata, v.err);
        if (v.rv && id_q.size() > 0) exp_q.push_back({id_q.pop_front(), v.err, v.rdata});
        @(negedge clk);
        chk({tag, " mem_req"}, bus.mem_req_o, v.exp_req);
        chk({tag, " host_gnt"}, bus.host_gnt_o, v.exp_gnt);
        chk({tag, " outstanding"}, bus.outstanding_o, v.exp_cnt);
        chk({tag, " mem_addr"}, bus.mem_addr_o, v.exp_req ? h_addr[v.exp_sel] : 32'h0);
        chk({tag, " mem_we"}, bus.mem_we_o, v.exp_req ? h_we[v.exp_sel] : 1'b0);
        chk({tag, " mem_be"}, bus.mem_be_o, v.exp_req ? h_be[v.exp_sel] : 4'h0);
        chk({tag, " mem_wdata"}, bus.mem_wdata_o, v.exp_req ? h_wdata[v.exp_sel] : 32'h0);
        check_rsp(tag);
        if (v.exp_req && v.gnt) id_q.push_back(v.exp_sel);
        @(posedge clk);
        #1;
    endtask

    initial begin
        h_addr[0] = 32'h1000_0000; h_we[0] = 1'b0; h_be[0] = 4'hF;
        h_addr[1] = 32'h2000_0004; h_we[1] = 1'b1; h_be[1] = 4'h3;
        for (int h = 0; h < NH; h++) begin
            bus.host_addr_i[h] = h_addr[h];
            bus.host_we_i[h]   = h_we[h];
            bus.host_be_i[h]   = h_be[h];
        end
        drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);

        // outputs held at zero during reset even with requests pending
        #12;
        chk("reset mem_req", bus.mem_req_o, 0);
        chk("reset host_gnt", bus.host_gnt_o, 0);
        chk("reset outstanding", bus.outstanding_o, 0);
        chk("reset spurious", bus.spurious_rvalid_o, 0);
        chk("reset lock", bus.lock_dbg_o, LOCK_IDLE);
        chk("reset mem_addr", bus.mem_addr_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        //    req    gnt   rv    rdata          err   ereq  egnt   esel  ecnt
        // alternating grants with a response one cycle after each grant
        add(2'b11, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 2'b01, 1'b0, 2'd0);
        add(2'b11, 1'b1, 1'b1, 32'hA1A1_0001, 1'b0, 1'b1, 2'b10, 1'b1, 2'd1);
        add(2'b11, 1'b1, 1'b1, 32'hA2A2_0002, 1'b0, 1'b1, 2'b01, 1'b0, 2'd1);
        add(2'b11, 1'b1, 1'b1, 32'hA3A3_0003, 1'b0, 1'b1, 2'b10, 1'b1, 2'd1);
        add(2'b00, 1'b0, 1'b1, 32'hA4A4_0004, 1'b1, 1'b0, 2'b00, 1'b0, 2'd1);
        // H1 locked while ungranted, H0 joins mid-way
        add(2'b10, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 2'b00, 1'b1, 2'd0);
        add(2'b11, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 2'b00, 1'b1, 2'd0);
        add(2'b11, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 2'b00, 1'b1, 2'd0);
        add(2'b11, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 2'b10, 1'b1, 2'd0);
        add(2'b11, 1'b1, 1'b1, 32'hB1B1_0001, 1'b0, 1'b1, 2'b01, 1'b0, 2'd1);
        add(2'b00, 1'b0, 1'b1, 32'hB2B2_0002, 1'b0, 1'b0, 2'b00, 1'b0, 2'd1);
        // fill the FIFO, no full-bypass on the popping cycle
        add(2'b11, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 2'b10, 1'b1, 2'd0);
        add(2'b11, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 2'b01, 1'b0, 2'd1);
        add(2'b11, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 2'b00, 1'b0, 2'd2);
        add(2'b11, 1'b1, 1'b1, 32'hC1C1_0001, 1'b0, 1'b0, 2'b00, 1'b0, 2'd2);
        add(2'b11, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 2'b10, 1'b1, 2'd1);
        add(2'b00, 1'b0, 1'b1, 32'hC2C2_0002, 1'b0, 1'b0, 2'b00, 1'b0, 2'd2);
        add(2'b00, 1'b0, 1'b1, 32'hC3C3_0003, 1'b1, 1'b0, 2'b00, 1'b0, 2'd1);
        // in-order responses with distinct data and error
        add(2'b01, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 2'b01, 1'b0, 2'd0);
        add(2'b10, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 2'b10, 1'b1, 2'd1);
        add(2'b00, 1'b0, 1'b1, 32'hAAAA_0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'd2);
        add(2'b00, 1'b0, 1'b1, 32'h0000_BBBB, 1'b1, 1'b0, 2'b00, 1'b0, 2'd1);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
        chk("drain outstanding", bus.outstanding_o, 0);

        // spurious response with nothing outstanding
        drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        chk("spur no_rvalid", bus.host_rvalid_o, 0);
        chk("spur before_edge", bus.spurious_rvalid_o, 0);
        @(posedge clk); #1;
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("spur set", bus.spurious_rvalid_o, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("spur sticky", bus.spurious_rvalid_o, 1);

        // reset while a lock is held and one transaction is outstanding
        drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("rst_seq accept_h0", bus.host_gnt_o, 2'b01);
        @(posedge clk); #1;
        drive(2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("rst_seq offer_h1", bus.mem_req_o, 1);
        @(posedge clk); #1;
        drive(2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("rst_seq lock_held", bus.lock_dbg_o, LOCK_HELD);
        chk("rst_seq outstanding", bus.outstanding_o, 1);
        chk("rst_seq locked_addr", bus.mem_addr_o, h_addr[1]);
        #1;
        rst = 1'b1;
        drive(2'b11, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
        #1;
        chk("mid_rst mem_req", bus.mem_req_o, 0);
        chk("mid_rst host_gnt", bus.host_gnt_o, 0);
        chk("mid_rst rvalid", bus.host_rvalid_o, 0);
        chk("mid_rst outstanding", bus.outstanding_o, 0);
        chk("mid_rst lock", bus.lock_dbg_o, LOCK_IDLE);
        chk("mid_rst spurious", bus.spurious_rvalid_o, 0);
        chk("mid_rst mem_addr", bus.mem_addr_o, 0);
        id_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(2'b00, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        @(negedge clk);
        chk("post_rst stale_rvalid", bus.host_rvalid_o, 0);
        @(posedge clk); #1;
        drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("post_rst h0_first", bus.host_gnt_o, 2'b01);
        chk("post_rst spurious", bus.spurious_rvalid_o, 1);
        @(posedge clk); #1;
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("post_rst outstanding", bus.outstanding_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
